// File: rtl/cache_refill_ctrl.sv
// Cache block refill controller: fetches one aligned 4-word block per miss.
// Optional refill counter output enabled by defining REFILL_STATS_EN.
module cache_refill_ctrl #(
  parameter int ADDR_W = 15,
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_W-1:0]     miss_addr,
  output logic                  busy,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  fill_valid,
  output logic [4*WORD_W-1:0]   fill_block,
  output logic [ADDR_W-1:0]     fill_addr
`ifdef REFILL_STATS_EN
  ,
  output logic [15:0]           refill_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-3:0]     base_q, base_d;
  logic [1:0]            k_q, k_d;
  logic [4*WORD_W-1:0]   buf_q, buf_d;
  logic [4*WORD_W-1:0]   blk_q, blk_d;
  logic [ADDR_W-1:0]     faddr_q, faddr_d;

  // Word offset bits never matter: the block base is always aligned.
  logic unused_offs;
  assign unused_offs = ^miss_addr[1:0];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    k_d     = k_q;
    buf_d   = buf_q;
    blk_d   = blk_q;
    faddr_d = faddr_q;
    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          base_d  = miss_addr[ADDR_W-1:2];
          k_d     = 2'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          buf_d[k_q*WORD_W +: WORD_W] = mem_rdata;
          k_d = k_q + 2'd1;
          // Publish only on completion so the visible block stays stable.
          if (k_q == 2'd3) begin
            blk_d   = {mem_rdata, buf_q[3*WORD_W-1:0]};
            faddr_d = {base_q, 2'b00};
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      k_q     <= '0;
      buf_q   <= '0;
      blk_q   <= '0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
      blk_q   <= blk_d;
      faddr_q <= faddr_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_rd     = (state_q == REQ);
  assign mem_addr   = mem_rd ? {base_q, k_q} : '0;
  assign fill_valid = (state_q == DONE);
  assign fill_block = blk_q;
  assign fill_addr  = faddr_q;

`ifdef REFILL_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fill_valid && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign refill_count = cnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: transaction model plus directed scenarios.
// Define REFILL_STATS_EN to also cover the refill counter.
module tb_cache_refill_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req;
  logic [14:0]   miss_addr;
  logic          busy;
  logic          mem_rd;
  logic [14:0]   mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic          fill_valid;
  logic [127:0]  fill_block;
  logic [14:0]   fill_addr;
`ifdef REFILL_STATS_EN
  logic [15:0]   refill_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit started = 0;

  always #5 clk = ~clk;

  assign mem_rdata = 32'h0000_00A0 + {17'd0, mem_addr};

  cache_refill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .busy       (busy),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .fill_valid (fill_valid),
    .fill_block (fill_block),
    .fill_addr  (fill_addr)
`ifdef REFILL_STATS_EN
    ,
    .refill_count (refill_count)
`endif
  );

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: 0 waiting, 1 collecting words, 2 block delivered
  int          m_phase;
  int          m_n;
  logic [14:0] m_base;
  logic [31:0] m_words [4];
  logic [127:0] e_blk;
  logic [14:0] e_addr;
  int          e_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_n     = 0;
      m_base  = '0;
      e_blk   = '0;
      e_addr  = '0;
      e_cnt   = 0;
    end else if (m_phase == 2) begin
      m_phase = 0;
      if (e_cnt < 65535) e_cnt++;
    end else if (m_phase == 1) begin
      if (mem_ack) begin
        m_words[m_n] = mem_rdata;
        m_n++;
        if (m_n == 4) begin
          m_phase = 2;
          e_blk   = {m_words[3], m_words[2], m_words[1], m_words[0]};
          e_addr  = m_base;
        end
      end
    end else if (miss_req) begin
      m_base  = miss_addr & 15'h7FFC;
      m_n     = 0;
      m_phase = 1;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      check("busy", busy, m_phase != 0);
      check("mem_rd", mem_rd, m_phase == 1);
      check("mem_addr", mem_addr,
            (m_phase == 1) ? 15'(m_base + 15'(m_n)) : 15'd0);
      check("fill_valid", fill_valid, m_phase == 2);
      check("fill_block", fill_block, e_blk);
      check("fill_addr", fill_addr, e_addr);
`ifdef REFILL_STATS_EN
      check("refill_count", refill_count, e_cnt);
`endif
    end
  end

  logic [14:0] addrs [$];

  // Runs one refill from the point just after an edge; returns fill edge.
  task automatic do_refill(input logic [14:0] a, input int waits,
                           input bit inject, output int efv);
    int wc = 0;
    int e = 0;
    efv = 0;
    addrs.delete();
    miss_req  = 1'b1;
    miss_addr = a;
    mem_ack   = 1'b1;
    while (e < 60 && efv == 0) begin
      @(posedge clk);
      #1;
      e++;
      miss_req = inject && (e == 3);
      if (inject && e == 3) miss_addr = 15'h0040;
      if (mem_rd) begin
        if (wc == waits) begin
          mem_ack = 1'b1;
          wc = 0;
        end else begin
          mem_ack = 1'b0;
          wc++;
        end
      end else begin
        mem_ack = 1'b1;
      end
      if (mem_rd && mem_ack) addrs.push_back(mem_addr);
      if (fill_valid) efv = e;
    end
    check("fill_seen", efv != 0, 1'b1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int efv;
  int fv_cnt;
  int fv_edges [$];

  initial begin
    rst       = 1'b1;
    miss_req  = 1'b0;
    miss_addr = '0;
    mem_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 15'd0);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_fill_block", fill_block, 128'd0);
    check("rst_fill_addr", fill_addr, 15'd0);
`ifdef REFILL_STATS_EN
    check("rst_count", refill_count, 16'd0);
`endif
    rst = 1'b0;
    started = 1;

    // Zero-wait refill
    do_refill(15'h0013, 0, 0, efv);
    check("zw_edge", efv, 5);
    check("zw_naddr", addrs.size(), 4);
    check("zw_addr0", addrs[0], 15'h0010);
    check("zw_addr3", addrs[3], 15'h0013);
    check("zw_block", fill_block,
          {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    check("zw_faddr", fill_addr, 15'h0010);
    @(posedge clk);
    #1;

    // Two wait cycles per word at the top of the address space
    do_refill(15'h7FFE, 2, 0, efv);
    check("ws_edge", efv, 13);
    check("ws_addr0", addrs[0], 15'h7FFC);
    check("ws_addr3", addrs[3], 15'h7FFF);
    check("ws_block", fill_block,
          {32'h809F, 32'h809E, 32'h809D, 32'h809C});
    check("ws_faddr", fill_addr, 15'h7FFC);
    @(posedge clk);
    #1;

    // Request raised while busy is dropped
    do_refill(15'h0020, 0, 1, efv);
    check("bd_edge", efv, 5);
    check("bd_faddr", fill_addr, 15'h0020);
    check("bd_addr3", addrs[3], 15'h0023);
    fv_cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (fill_valid || busy) fv_cnt++;
    end
    check("bd_no_second", fv_cnt, 0);

    // Reset after two acks
    miss_req  = 1'b1;
    miss_addr = 15'h0105;
    mem_ack   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      miss_req = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("mr_busy", busy, 1'b0);
    check("mr_mem_rd", mem_rd, 1'b0);
    check("mr_mem_addr", mem_addr, 15'd0);
    check("mr_fill_valid", fill_valid, 1'b0);
    check("mr_fill_block", fill_block, 128'd0);
    check("mr_fill_addr", fill_addr, 15'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fv_cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (fill_valid) fv_cnt++;
    end
    check("mr_no_fill", fv_cnt, 0);
    do_refill(15'h0105, 0, 0, efv);
    check("mr_edge", efv, 5);
    check("mr_faddr", fill_addr, 15'h0104);
    check("mr_block", fill_block,
          {32'h1A7, 32'h1A6, 32'h1A5, 32'h1A4});
    @(posedge clk);
    #1;

    // Back-to-back with miss_req held high
    reset_pulse();
    miss_req  = 1'b1;
    miss_addr = 15'h0100;
    mem_ack   = 1'b1;
    for (int e = 1; e <= 40 && fv_edges.size() < 2; e++) begin
      @(posedge clk);
      #1;
      if (fill_valid) fv_edges.push_back(e);
    end
    miss_req = 1'b0;
    check("b2b_count", fv_edges.size(), 2);
    if (fv_edges.size() == 2) begin
      check("b2b_first", fv_edges[0], 5);
      check("b2b_second", fv_edges[1], 11);
    end
    @(posedge clk);
    #1;
`ifdef REFILL_STATS_EN
    check("stat_two", refill_count, 16'd2);
    miss_req = 1'b1;
    repeat (65536 * 6 + 12) @(posedge clk);
    #1;
    miss_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("stat_sat", refill_count, 16'hFFFF);
`endif
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
